// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the pipelined register file
package regfile_pkg;

    localparam int RF_ZERO_REG = 0;
    localparam int RF_SHOW_DW  = 32;

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_regfile_if.sv
// rtl/pipe_regfile_if.sv - decode/writeback/debug bundle between the pipeline and the register file
interface pipe_regfile_if
    import regfile_pkg::*;
#(
    parameter int DW    = RF_SHOW_DW,
    parameter int DEPTH = 32,
    parameter int NRD   = 2
);
    localparam int AW = rf_aw(DEPTH);

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic [AW-1:0]     show_addr;
    logic [DW-1:0]     show_data;
    logic [DEPTH-1:0]  busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, show_addr,
        input  rd_data, rd_busy, show_data, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, show_addr,
        output rd_data, rd_busy, show_data, busy_vec
    );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: zero register, then writeback bypass, then array
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_arr_data,
    input  logic          i_byp_en,
    input  logic [AW-1:0] i_byp_addr,
    input  logic [DW-1:0] i_byp_data,
    output logic [DW-1:0] o_data
);

    always_comb begin
        o_data = i_arr_data;
        if (i_addr == AW'(RF_ZERO_REG)) begin
            o_data = '0;
        end else if (i_byp_en && (i_byp_addr == i_addr)) begin
            o_data = i_byp_data;
        end
    end

endmodule

// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - register file with bypass, hardwired zero register and RAW pending scoreboard
module pipe_regfile
    import regfile_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2
) (
    input  logic           clk,
    input  logic           rst,
    pipe_regfile_if.slave  bus
);
    localparam int AW = rf_aw(DEPTH);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;

    logic             w_byp_en;
    logic [AW-1:0]    w_addr      [NRD+1];
    logic [DW-1:0]    w_port_data [NRD+1];

    // Bypass is masked during reset so every output reads 0 regardless of wr_*.
    assign w_byp_en = bus.wr_en & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (bus.wr_en && (bus.wr_addr != AW'(RF_ZERO_REG))) begin
                r_mem[bus.wr_addr] <= bus.wr_data;
            end
            // Issue wins over writeback: a new producer is outstanding.
            for (int r = 1; r < DEPTH; r++) begin
                if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
                    r_pend[r] <= 1'b1;
                end else if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
                    r_pend[r] <= 1'b0;
                end
            end
            r_pend[RF_ZERO_REG] <= 1'b0;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_addr
            assign w_addr[k] = bus.rd_addr[k*AW +: AW];
        end
        assign w_addr[NRD] = bus.show_addr;

        for (k = 0; k <= NRD; k++) begin : g_port
            regfile_rd_port #(
                .DW (DW),
                .AW (AW)
            ) u_port (
                .i_addr     (w_addr[k]),
                .i_arr_data (r_mem[w_addr[k]]),
                .i_byp_en   (w_byp_en),
                .i_byp_addr (bus.wr_addr),
                .i_byp_data (bus.wr_data),
                .o_data     (w_port_data[k])
            );
        end

        for (k = 0; k < NRD; k++) begin : g_out
            assign bus.rd_data[k*DW +: DW] = w_port_data[k];
            assign bus.rd_busy[k] = r_pend[w_addr[k]] &
                                    ~(bus.wr_en & (bus.wr_addr == w_addr[k]));
        end
    endgenerate

    assign bus.show_data = w_port_data[NRD];
    assign bus.busy_vec  = r_pend;

endmodule

// File: tb/tb_pipe_regfile.sv
// tb/tb_pipe_regfile.sv - scoreboard bench driving a 32x32x2 and a 16x8x3 build in lockstep
module tb_pipe_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  ra [3];
    logic [4:0]  show_a, wa, ia;
    logic        we, ie;
    logic [31:0] wd;

    pipe_regfile_if #(.DW(32), .DEPTH(32), .NRD(2)) ifa ();
    pipe_regfile_if #(.DW(16), .DEPTH(8),  .NRD(3)) ifb ();

    assign ifa.rd_addr   = {ra[1], ra[0]};
    assign ifa.wr_en     = we;
    assign ifa.wr_addr   = wa;
    assign ifa.wr_data   = wd;
    assign ifa.iss_en    = ie;
    assign ifa.iss_addr  = ia;
    assign ifa.show_addr = show_a;

    assign ifb.rd_addr   = {ra[2][2:0], ra[1][2:0], ra[0][2:0]};
    assign ifb.wr_en     = we;
    assign ifb.wr_addr   = wa[2:0];
    assign ifb.wr_data   = wd[15:0];
    assign ifb.iss_en    = ie;
    assign ifb.iss_addr  = ia[2:0];
    assign ifb.show_addr = show_a[2:0];

    pipe_regfile #(.DW(32), .DEPTH(32), .NRD(2)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pipe_regfile #(.DW(16), .DEPTH(8),  .NRD(3)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mem  [2][32];
    logic        pend [2][32];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int depth_of(input int w);
        return (w == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] dmask(input int w);
        return (w == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] m_read(input int w, input int addr);
        int a    = addr % depth_of(w);
        int wa_m = int'(wa) % depth_of(w);
        if (rst || a == 0) return 32'h0;
        if (we && wa_m == a) return wd & dmask(w);
        return mem[w][a];
    endfunction

    function automatic logic m_busy(input int w, input int addr);
        int a    = addr % depth_of(w);
        int wa_m = int'(wa) % depth_of(w);
        if (rst) return 1'b0;
        return pend[w][a] && !(we && wa_m == a);
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int r = 0; r < 32; r++) begin
                mem[w][r]  = 32'h0;
                pend[w][r] = 1'b0;
            end
    endtask

    task automatic model_edge();
        if (rst) return;
        for (int w = 0; w < 2; w++) begin
            int wa_m = int'(wa) % depth_of(w);
            int ia_m = int'(ia) % depth_of(w);
            if (we && wa_m != 0) mem[w][wa_m] = wd & dmask(w);
            for (int r = 1; r < depth_of(w); r++) begin
                if (ie && ia_m == r)      pend[w][r] = 1'b1;
                else if (we && wa_m == r) pend[w][r] = 1'b0;
            end
        end
    endtask

    task automatic sb_expect();
        for (int w = 0; w < 2; w++) begin
            logic [31:0] bv = 32'h0;
            for (int k = 0; k < ((w == 0) ? 2 : 3); k++) begin
                sbq.push_back('{$sformatf("dut%0d rd_data%0d", w, k), m_read(w, int'(ra[k]))});
                sbq.push_back('{$sformatf("dut%0d rd_busy%0d", w, k), {31'h0, m_busy(w, int'(ra[k]))}});
            end
            sbq.push_back('{$sformatf("dut%0d show_data", w), m_read(w, int'(show_a))});
            for (int r = 0; r < depth_of(w); r++) bv[r] = rst ? 1'b0 : pend[w][r];
            sbq.push_back('{$sformatf("dut%0d busy_vec", w), bv});
        end
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            check_val("scoreboard_underflow", obs, ~obs);
        end else begin
            e = sbq.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic sb_observe();
        for (int k = 0; k < 2; k++) begin
            pop_cmp(ifa.rd_data[k*32 +: 32]);
            pop_cmp({31'h0, ifa.rd_busy[k]});
        end
        pop_cmp(ifa.show_data);
        pop_cmp(ifa.busy_vec);
        for (int k = 0; k < 3; k++) begin
            pop_cmp({16'h0, ifb.rd_data[k*16 +: 16]});
            pop_cmp({31'h0, ifb.rd_busy[k]});
        end
        pop_cmp({16'h0, ifb.show_data});
        pop_cmp({24'h0, ifb.busy_vec});
    endtask

    task automatic tick();
        #2;
        sb_expect();
        sb_observe();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        we = 1'b0;
        ie = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] s);
        ra[0]  = a0;
        ra[1]  = a1;
        ra[2]  = a2;
        show_a = s;
    endtask

    task automatic set_write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
    endtask

    task automatic set_issue(input logic [4:0] a);
        ie = 1'b1;
        ia = a;
    endtask

    initial begin
        we = 1'b0; ie = 1'b0; wa = '0; ia = '0; wd = '0;
        set_reads(5'd5, 5'd5, 5'd5, 5'd5);
        model_reset();
        // Outputs read 0 during reset even with an active writeback.
        set_write(5'd5, 32'hDEAD_BEEF);
        tick();
        rst = 1'b0;

        set_write(5'd5, 32'hDEAD_BEEF);
        set_issue(5'd6);
        tick();
        set_reads(5'd5, 5'd6, 5'd6, 5'd5);
        tick();

        // Asynchronous reset pulse mid-cycle, with a write that must be dropped.
        #1;
        rst = 1'b1;
        model_reset();
        set_write(5'd5, 32'h0000_0111);
        tick();
        rst = 1'b0;
        tick();

        set_write(5'd3, 32'h1234_5678);
        tick();
        set_reads(5'd3, 5'd3, 5'd3, 5'd3);
        tick();

        set_write(5'd8, 32'h0BAD_F00D);
        tick();
        set_reads(5'd7, 5'd8, 5'd7, 5'd8);
        set_write(5'd7, 32'hA5A5_A5A5);
        tick();
        tick();

        set_reads(5'd0, 5'd0, 5'd0, 5'd0);
        set_write(5'd0, 32'hFFFF_FFFF);
        set_issue(5'd0);
        tick();
        tick();

        set_reads(5'd4, 5'd3, 5'd4, 5'd4);
        set_issue(5'd4);
        tick();
        tick();
        set_write(5'd4, 32'h0000_4444);
        tick();
        tick();

        set_reads(5'd9, 5'd1, 5'd9, 5'd9);
        set_write(5'd9, 32'h0000_0055);
        set_issue(5'd9);
        tick();
        tick();

        for (int i = 0; i < 60; i++) begin
            set_reads(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) set_write(5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 2) == 0) set_issue(5'($urandom_range(0, 31)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
